// File: rtl/ysyx_23060201_fetch_queue.sv
// rtl/ysyx_23060201_fetch_queue.sv - IFU-to-IDU instruction fetch queue
// Circular buffer of {pc, inst} pairs; a redirect (flush) discards every entry.
module ysyx_23060201_fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [PTR_WIDTH:0]    count
);
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] ONE        = (PTR_WIDTH+1)'(1);

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
  logic [PTR_WIDTH:0]    wr_ptr;
  logic [PTR_WIDTH:0]    rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  ptr_empty;
  logic                  ptr_full;

  // Flow control looks only at registered count, so out_ready never reaches in_ready.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign ptr_empty = (wr_ptr == rd_ptr);
  assign ptr_full  = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) &&
                     (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);

  assign out_pc   = out_valid ? pc_mem[rd_ptr[PTR_WIDTH-1:0]]   : '0;
  assign out_inst = out_valid ? inst_mem[rd_ptr[PTR_WIDTH-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      if (push && !pop)      count <= count + ONE;
      else if (pop && !push) count <= count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[PTR_WIDTH-1:0]]   <= in_pc;
      inst_mem[wr_ptr[PTR_WIDTH-1:0]] <= in_inst;
    end
  end

`ifndef SYNTHESIS
  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count <= FULL_COUNT);
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count == FULL_COUNT));
  a_empty_agree: assert property (@(posedge clk) disable iff (!rst_n)
    ptr_empty == (count == '0));
  a_full_agree: assert property (@(posedge clk) disable iff (!rst_n)
    ptr_full == (count == FULL_COUNT));
  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !flush) |=> ($stable(out_pc) && $stable(out_inst)));
`endif
endmodule
